// File: rtl/multi_lane_sh_shifter.sv
// Multi-lane bit-slip channel model: each 66-bit lane is delayed by a programmable
// bit offset inside a two-block window, with RF writes, broadcast and slow drift.
module multi_lane_sh_shifter #(
  parameter int unsigned NB_CODED_BLOCK  = 66,
  parameter int unsigned N_LANES         = 20,
  parameter int unsigned NB_SHIFT_INDEX  = $clog2(NB_CODED_BLOCK),
  parameter int unsigned NB_LANE_SEL     = $clog2(N_LANES),
  parameter int unsigned NB_DRIFT_PERIOD = 16
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic                                 i_valid,
  input  logic [N_LANES*NB_CODED_BLOCK-1:0]    i_data,
  input  logic                                 i_rf_update,
  input  logic                                 i_rf_broadcast,
  input  logic [NB_LANE_SEL-1:0]               i_rf_lane_sel,
  input  logic [NB_SHIFT_INDEX-1:0]            i_rf_sh_pos,
  input  logic                                 i_rf_drift_enable,
  input  logic [N_LANES-1:0]                   i_rf_drift_mask,
  input  logic [NB_DRIFT_PERIOD-1:0]           i_rf_drift_period,
  output logic [N_LANES*NB_CODED_BLOCK-1:0]    o_data,
  output logic                                 o_valid,
  output logic [N_LANES*NB_SHIFT_INDEX-1:0]    o_sh_pos,
  output logic                                 o_rf_error,
  output logic [N_LANES-1:0]                   o_drift_wrap
);

  localparam int unsigned NB     = NB_CODED_BLOCK;
  localparam int unsigned NB_BUS = N_LANES * NB;
  localparam int unsigned NB_POS = N_LANES * NB_SHIFT_INDEX;
  localparam logic [NB_SHIFT_INDEX-1:0]  SH_MAX  = NB_SHIFT_INDEX'(NB - 1);
  localparam logic [NB_SHIFT_INDEX-1:0]  SH_ONE  = NB_SHIFT_INDEX'(1);
  localparam logic [NB_DRIFT_PERIOD-1:0] CNT_ONE = NB_DRIFT_PERIOD'(1);

  logic [NB_BUS-1:0]          prev_q, prev_d, data_q, data_d;
  logic                       valid_q, valid_d;
  logic [NB_POS-1:0]          sh_q, sh_d;
  logic                       pend_q, pend_d, pend_bcast_q, pend_bcast_d;
  logic [NB_LANE_SEL-1:0]     pend_lane_q, pend_lane_d;
  logic [NB_SHIFT_INDEX-1:0]  pend_pos_q, pend_pos_d;
  logic                       upd_q, upd_d;
  logic [NB_DRIFT_PERIOD-1:0] cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [N_LANES-1:0]         wrap_q, wrap_d;

  logic                       upd_edge, req_ok, req_pend, req_bcast, apply, drift_step;
  logic [NB_LANE_SEL-1:0]     req_lane;
  logic [NB_SHIFT_INDEX-1:0]  req_pos;
  logic [NB-1:0]              shifted [N_LANES];

  // Per-lane window slice W[2*NB-1-sh : NB-sh] of {prev, cur}
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign shifted[k] = NB'({prev_q[k*NB +: NB], i_data[k*NB +: NB]} >>
                            (NB - 32'(sh_q[k*NB_SHIFT_INDEX +: NB_SHIFT_INDEX])));
  end

  always_comb begin
    upd_edge = i_rf_update & ~upd_q;
    req_ok   = (32'(i_rf_sh_pos) < NB) &&
               (i_rf_broadcast || (32'(i_rf_lane_sel) < N_LANES));
    err_d    = upd_edge & ~req_ok;

    // A fresh valid request replaces any pending one; it lands on the next valid edge
    req_pend  = pend_q;
    req_bcast = pend_bcast_q;
    req_lane  = pend_lane_q;
    req_pos   = pend_pos_q;
    if (upd_edge && req_ok) begin
      req_pend  = 1'b1;
      req_bcast = i_rf_broadcast;
      req_lane  = i_rf_lane_sel;
      req_pos   = i_rf_sh_pos;
    end
    apply        = i_valid & req_pend;
    pend_d       = req_pend & ~i_valid;
    pend_bcast_d = req_bcast;
    pend_lane_d  = req_lane;
    pend_pos_d   = req_pos;

    cnt_d      = cnt_q;
    drift_step = 1'b0;
    if (!i_rf_drift_enable || (i_rf_drift_period == '0)) begin
      cnt_d = '0;
    end else if (i_valid) begin
      if (cnt_q == (i_rf_drift_period - CNT_ONE)) begin
        cnt_d      = '0;
        drift_step = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    valid_d = i_valid;
    upd_d   = i_rf_update;
    prev_d  = i_valid ? i_data : prev_q;
    data_d  = data_q;
    sh_d    = sh_q;
    wrap_d  = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (i_valid) begin
        data_d[k*NB +: NB] = shifted[k];
      end
      if (apply && (req_bcast || (32'(req_lane) == k))) begin
        sh_d[k*NB_SHIFT_INDEX +: NB_SHIFT_INDEX] = req_pos;
      end else if (drift_step && i_rf_drift_mask[k]) begin
        if (sh_q[k*NB_SHIFT_INDEX +: NB_SHIFT_INDEX] == SH_MAX) begin
          sh_d[k*NB_SHIFT_INDEX +: NB_SHIFT_INDEX] = '0;
          wrap_d[k] = 1'b1;
        end else begin
          sh_d[k*NB_SHIFT_INDEX +: NB_SHIFT_INDEX] =
            sh_q[k*NB_SHIFT_INDEX +: NB_SHIFT_INDEX] + SH_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      prev_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sh_q         <= '0;
      pend_q       <= 1'b0;
      pend_bcast_q <= 1'b0;
      pend_lane_q  <= '0;
      pend_pos_q   <= '0;
      upd_q        <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wrap_q       <= '0;
    end else begin
      prev_q       <= prev_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      sh_q         <= sh_d;
      pend_q       <= pend_d;
      pend_bcast_q <= pend_bcast_d;
      pend_lane_q  <= pend_lane_d;
      pend_pos_q   <= pend_pos_d;
      upd_q        <= upd_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_sh_pos     = sh_q;
  assign o_rf_error   = err_q;
  assign o_drift_wrap = wrap_q;

endmodule

// File: doc/multi_lane_sh_shifter.md
Name: multi_lane_sh_shifter

Overview:
- Multi-lane bit-slip channel model for the PCS test environment.
- Sits between the lane distributor / encoded-block source and the receive-side block-lock logic.
- Each of N_LANES 66-bit coded-block lanes is independently delayed by a programmable bit offset (0..NB_CODED_BLOCK-1) inside a two-block window.
- Adds per-lane register-file updates, broadcast, out-of-range rejection and an automatic drift mode that emulates slow clock slip.

Parameters:
- NB_CODED_BLOCK, 66, bits per coded block.
- N_LANES, 20, number of lanes.
- NB_SHIFT_INDEX, $clog2(NB_CODED_BLOCK), width of a shift position.
- NB_LANE_SEL, $clog2(N_LANES), width of the lane selector.
- NB_DRIFT_PERIOD, 16, width of the drift period counter.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  one block per lane on i_data this cycle.
- i_data  in  N_LANES*NB_CODED_BLOCK  lane k at bits [k*NB+:NB].
- i_rf_update  in  1  level; its rising edge requests a shift write.
- i_rf_broadcast  in  1  with update: write all lanes.
- i_rf_lane_sel  in  NB_LANE_SEL  target lane when not broadcast.
- i_rf_sh_pos  in  NB_SHIFT_INDEX  new shift position.
- i_rf_drift_enable  in  1  enables drift mode.
- i_rf_drift_mask  in  N_LANES  lanes subject to drift.
- i_rf_drift_period  in  NB_DRIFT_PERIOD  valid blocks between drift steps; 0 means no drift.
- o_data  out  N_LANES*NB_CODED_BLOCK  shifted blocks.
- o_valid  out  1  registered i_valid.
- o_sh_pos  out  N_LANES*NB_SHIFT_INDEX  current per-lane shift positions.
- o_rf_error  out  1  one-cycle pulse: rejected write.
- o_drift_wrap  out  N_LANES  one-cycle pulse per lane: drift wrapped NB-1 to 0.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - Clears prev_reg, o_data, o_valid, o_sh_pos, the pending-write register, the update edge detector, the drift counter, o_rf_error and o_drift_wrap.
  - Takes effect immediately mid-stream, including on a pending write.
- Datapath, per lane, on clock edge with i_valid=1:
  - Window W = {prev_reg, i_data_lane}, 2*NB bits.
  - o_data_lane <= W[2*NB-1-sh : NB-sh].
  - prev_reg <= i_data_lane.
  - sh=0 outputs the previous block, i.e. one valid block of latency.
  - When i_valid=0: o_data and prev_reg hold.
  - o_valid <= i_valid every cycle.
- RF write:
  - Detected on a 0->1 transition of i_rf_update; holding the level high does not repeat the write.
  - Validated on the edge cycle. Reject if i_rf_sh_pos >= NB, or if not broadcast and i_rf_lane_sel >= N_LANES.
  - On reject: o_rf_error=1 on the next cycle; no state change.
  - A valid request is latched as pending and applied at the next edge with i_valid=1, so a block is never torn.
  - The new position is used for the block accepted on the edge following the apply edge.
  - A second valid request while pending overwrites the first.
  - If the edge coincides with an i_valid=1 cycle, the write applies on that same edge.
- Drift:
  - Counter increments on each valid cycle while i_rf_drift_enable=1 and period!=0.
  - When count == period-1: counter returns to 0, and every masked lane does sh <= (sh==NB-1) ? 0 : sh+1.
  - o_drift_wrap pulses for lanes that wrapped.
  - Deasserting enable clears the counter; positions keep their values.
  - Same-edge conflict: an RF write to a lane wins over drift for that lane; the counter still resets.
- o_sh_pos always reflects the registered positions used by the datapath.

Test Plan:
- Reset then lane 0 fed prev=66'h0, cur=66'h3_FFFF_FFFF_FFFF_FFFF, sh=10 -> lane 0 o_data=66'h0_0000_0000_0000_03FF; sh=0 -> 66'h0; sh=65 -> 66'h1_FFFF_FFFF_FFFF_FFFF.
- Walk a single-one block 66'h2_0000_0000_0000_0000 through sh 0,1,2,3,10,11,12,20,34,64,65 on lane 5, writing via lane_sel=5 -> the one appears at the bit index implied by the window formula; other lanes stay unshifted.
- Write sh_pos=66, then 127, then lane_sel=20 -> o_rf_error pulses once each; o_sh_pos unchanged. Hold i_rf_update high 4 cycles -> exactly one write.
- Write during i_valid=0 gaps -> the position applies only at the next valid edge; a double write in the gap -> last value wins.
- Drift enabled, period=3, mask=lane 2, initial sh=64 -> lane 2 sh goes to 65 after 3 valid blocks, then 0 after 6 with o_drift_wrap[2] pulsed. RF write to lane 2 on the drift edge -> RF value wins.
- Assert i_reset mid-stream with a write pending -> all outputs 0 immediately; after release, the pending write is not applied.
